// File: rtl/aes_dec_ctrl_if.sv
// Handshake/data bundle between the crypto register block and aes_dec_ctrl.
//   in_valid/in_ready   : request handshake carrying cipher + secret
//   out_valid/out_ready : result handshake carrying plaintext
//   busy, round         : status/debug
// Byte 0 of every 128-bit field sits at [127:120], column-major FIPS-197 order.
interface aes_dec_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] cipher;
    logic [127:0] secret;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plaintext;
    logic         busy;
    logic [3:0]   round;

    modport slave (
        input  in_valid, cipher, secret, out_ready,
        output in_ready, out_valid, plaintext, busy, round
    );

    modport master (
        output in_valid, cipher, secret, out_ready,
        input  in_ready, out_valid, plaintext, busy, round
    );
endinterface

// File: rtl/aes_dec_ctrl.sv
// Iterative AES-128 decryption engine with its own sequencer.
// Accepts a ciphertext/key pair, expands the key forward to rk10 (one step per
// cycle), runs the ten inverse rounds one per cycle while stepping the key
// schedule backward, then holds the plaintext until it is accepted.
// Ports:
//   clock    : rising-edge clock
//   reset_n  : synchronous active-low reset
//   bus      : aes_dec_ctrl_if.slave (request, result and status signals)
// Optional feature: define AES_DEC_KEYCACHE_EN to keep the last expanded rk10
// and skip key expansion when the same key is presented again.
module aes_dec_ctrl (
    input  logic          clock,
    input  logic          reset_n,
    aes_dec_ctrl_if.slave bus
);
    localparam int unsigned BLK_W = 128;
    localparam int unsigned RND_W = 4;
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(10);

    typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_e;

    state_e           state_q, state_d;
    logic [RND_W-1:0] round_q, round_d;
    logic [BLK_W-1:0] data_q, data_d;
    logic [BLK_W-1:0] key_q, key_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [BLK_W-1:0] plaintext_q, plaintext_d;
    logic [BLK_W-1:0] fwd_rk_c, prev_rk_c, inv_core_c;

`ifdef AES_DEC_KEYCACHE_EN
    logic             cache_vld_q, cache_vld_d;
    logic [BLK_W-1:0] cache_key_q, cache_key_d;
    logic [BLK_W-1:0] cache_rk_q, cache_rk_d;
    logic [BLK_W-1:0] req_key_q, req_key_d;
    logic             cache_hit_c;
`endif

    // GF(2^8) helpers, polynomial 0x11b
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box needs)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] res;
        logic [7:0] base;
        res  = 8'h01;
        base = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) res = gf_mul(res, base);
            base = gf_mul(base, base);
        end
        return res;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [RND_W-1:0] idx);
        case (idx)
            RND_W'(1):  return 8'h01;
            RND_W'(2):  return 8'h02;
            RND_W'(3):  return 8'h04;
            RND_W'(4):  return 8'h08;
            RND_W'(5):  return 8'h10;
            RND_W'(6):  return 8'h20;
            RND_W'(7):  return 8'h40;
            RND_W'(8):  return 8'h80;
            RND_W'(9):  return 8'h1b;
            RND_W'(10): return 8'h36;
            default:    return 8'h00;
        endcase
    endfunction

    // SubWord(RotWord(w)) ^ rcon, shared by forward and backward key steps
    function automatic logic [31:0] key_core(input logic [31:0] w, input logic [7:0] rc);
        return {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [BLK_W-1:0] key_fwd(input logic [BLK_W-1:0] k, input logic [7:0] rc);
        logic [31:0] n0, n1, n2, n3;
        n0 = k[127:96] ^ key_core(k[31:0], rc);
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0]  ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Recover the previous round key: later words first, then word 0
    function automatic logic [BLK_W-1:0] key_inv(input logic [BLK_W-1:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0]  ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ key_core(w3, rc);
        return {w0, w1, w2, w3};
    endfunction

    // InvShiftRows then InvSubBytes; byte k is row k%4, column k/4
    function automatic logic [BLK_W-1:0] inv_shift_sub(input logic [BLK_W-1:0] blk);
        logic [BLK_W-1:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[BLK_W-1-8*(4*c+r) -: 8] =
                    inv_sbox(blk[BLK_W-1-8*(4*((c+4-r)%4)+r) -: 8]);
            end
        end
        return res;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    function automatic logic [BLK_W-1:0] inv_mix_columns(input logic [BLK_W-1:0] blk);
        logic [BLK_W-1:0] res;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            res[BLK_W-1-32*c -: 32] = inv_mix_col(blk[BLK_W-1-32*c -: 32]);
        end
        return res;
    endfunction

    // Datapath: forward key step, backward key step, shared inverse-round core
    assign fwd_rk_c   = key_fwd(key_q, rcon(round_q));
    assign prev_rk_c  = key_inv(key_q, rcon(RND_W'(11) - round_q));
    assign inv_core_c = inv_shift_sub(data_q) ^ prev_rk_c;

`ifdef AES_DEC_KEYCACHE_EN
    assign cache_hit_c = cache_vld_q && (bus.secret == cache_key_q);
`endif

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        data_d      = data_q;
        key_d       = key_q;
`ifdef AES_DEC_KEYCACHE_EN
        cache_vld_d = cache_vld_q;
        cache_key_d = cache_key_q;
        cache_rk_d  = cache_rk_q;
        req_key_d   = req_key_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    round_d = RND_W'(1);
`ifdef AES_DEC_KEYCACHE_EN
                    if (cache_hit_c) begin
                        key_d   = cache_rk_q;
                        data_d  = bus.cipher ^ cache_rk_q;
                        state_d = ROUND;
                    end else begin
                        key_d     = bus.secret;
                        data_d    = bus.cipher;
                        req_key_d = bus.secret;
                        state_d   = KEYEXP;
                    end
`else
                    key_d   = bus.secret;
                    data_d  = bus.cipher;
                    state_d = KEYEXP;
`endif
                end
            end
            KEYEXP: begin
                key_d   = fwd_rk_c;
                round_d = round_q + RND_W'(1);
                if (round_q == LAST_RND) begin
                    data_d  = data_q ^ fwd_rk_c;
                    round_d = RND_W'(1);
                    state_d = ROUND;
`ifdef AES_DEC_KEYCACHE_EN
                    cache_vld_d = 1'b1;
                    cache_key_d = req_key_q;
                    cache_rk_d  = fwd_rk_c;
`endif
                end
            end
            ROUND: begin
                key_d   = prev_rk_c;
                round_d = round_q + RND_W'(1);
                if (round_q == LAST_RND) begin
                    data_d  = inv_core_c;
                    round_d = '0;
                    state_d = DONE;
                end else begin
                    data_d  = inv_mix_columns(inv_core_c);
                end
            end
            DONE: begin
                if (out_valid_q && bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d == KEYEXP) || (state_d == ROUND);
        // First DONE cycle is the entry cycle; out_valid follows one cycle later
        out_valid_d = (state_q == DONE) && (state_d == DONE);
        plaintext_d = out_valid_d ? data_q : '0;
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            round_q     <= '0;
            data_q      <= '0;
            key_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            plaintext_q <= '0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            data_q      <= data_d;
            key_q       <= key_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            plaintext_q <= plaintext_d;
        end
    end

`ifdef AES_DEC_KEYCACHE_EN
    // Key cache registers; reset invalidates the entry
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cache_vld_q <= 1'b0;
            cache_key_q <= '0;
            cache_rk_q  <= '0;
            req_key_q   <= '0;
        end else begin
            cache_vld_q <= cache_vld_d;
            cache_key_q <= cache_key_d;
            cache_rk_q  <= cache_rk_d;
            req_key_q   <= req_key_d;
        end
    end
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.plaintext = plaintext_q;
    assign bus.busy      = busy_q;
    assign bus.round     = round_q;
endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Testbench for aes_dec_ctrl: FIPS-197 vectors from a table, backpressure,
// ignored requests, mid-round reset and random keys/plaintexts checked against
// a forward AES-128 encryption model (encrypt here, expect the DUT to undo it).
module tb_aes_dec_ctrl;
    logic clock;
    logic reset_n;

    aes_dec_ctrl_if bus ();

    aes_dec_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

`ifdef AES_DEC_KEYCACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

    typedef struct packed {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t         vecs [5];
    int           n_checks;
    int           n_fail;
    logic [7:0]   tb_sbox [256];
    bit           m_cache_vld;
    logic [127:0] m_cache_key;
    int           exp_lat_g;
    logic [127:0] rkey;
    logic [127:0] rpt;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box by walking generator 3 and its inverse together
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            tb_sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        tb_sbox[0] = 8'h63;
    endtask

    // Forward AES-128 encryption reference
    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tb_sbox[tmp[23:16]], tb_sbox[tmp[15:8]], tb_sbox[tmp[7:0]],
                       tb_sbox[tmp[31:24]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int k = 0; k < 16; k++)
                t[k] = tb_sbox[s[4*(((k/4) + (k%4)) % 4) + (k%4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4*r + k/4][31-8*(k%4) -: 8];
        end
        res = '0;
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
        return res;
    endfunction

    function automatic int expected_latency(input logic [127:0] key);
        return (CACHE_EN && m_cache_vld && (m_cache_key == key)) ? 11 : 21;
    endfunction

    // Full request: accept, measure latency, optional hold in DONE, release
    task automatic run_req(input string name, input logic [127:0] key, input logic [127:0] ct,
                           input logic [127:0] pt, input int hold, input bit garbage);
        int exp_lat;
        int n;
        int lat;
        exp_lat = expected_latency(key);
        bus.secret   = key;
        bus.cipher   = ct;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 40) begin
            tick();
            n++;
        end
        check({name, " in_ready"}, 160'(bus.in_ready), 160'(1));
        tick();
        bus.in_valid = 1'b0;
        check({name, " busy"}, 160'(bus.busy), 160'(1));
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            if (garbage && lat >= exp_lat - 9 && lat <= exp_lat - 3) begin
                bus.in_valid = lat[0];
                bus.cipher   = rand128();
                bus.secret   = rand128();
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            lat++;
        end
        bus.in_valid = 1'b0;
        check({name, " latency"}, 160'(lat), 160'(exp_lat));
        check({name, " plaintext"}, 160'(bus.plaintext), 160'(pt));
        if (exp_lat == 21) begin
            m_cache_vld = 1'b1;
            m_cache_key = key;
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            check({name, " hold"}, 160'({bus.out_valid, bus.in_ready, bus.plaintext}),
                  160'({1'b1, 1'b0, pt}));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({name, " release"}, 160'({bus.out_valid, bus.in_ready, bus.busy, bus.plaintext}),
              160'({1'b0, 1'b1, 1'b0, 128'h0}));
        if (garbage) begin
            repeat (3) tick();
            check({name, " no_extra"}, 160'({bus.busy, bus.out_valid, bus.in_ready}),
                  160'(3'b001));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{key: K1, ct: C1, pt: P1};
        vecs[1] = '{key: K1, ct: C1, pt: P1};
        vecs[2] = '{key: K2, ct: C2, pt: P2};
        vecs[3] = '{key: K1, ct: C1, pt: P1};
        vecs[4] = '{key: K2, ct: C2, pt: P2};
        build_sbox();
        m_cache_vld   = 1'b0;
        m_cache_key   = '0;
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.cipher    = '0;
        bus.secret    = '0;

        repeat (3) tick();
        check("reset_state", 160'({bus.in_ready, bus.out_valid, bus.busy, bus.round, bus.plaintext}),
              160'(0));
        reset_n = 1'b1;
        tick();
        check("in_ready_after_reset", 160'({bus.in_ready, bus.busy}), 160'(2'b10));

        for (int i = 0; i < 5; i++)
            run_req($sformatf("vec%0d", i), vecs[i].key, vecs[i].ct, vecs[i].pt, 0, 1'b0);

        run_req("backpressure", K1, C1, P1, 15, 1'b0);
        run_req("ignored_req", K2, C2, P2, 0, 1'b1);

        // Reset while in round 5
        exp_lat_g    = expected_latency(K1);
        bus.secret   = K1;
        bus.cipher   = C1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (exp_lat_g - 7) tick();
        check("mid_round", 160'({bus.busy, bus.round}), 160'({1'b1, 4'd5}));
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        m_cache_vld = 1'b0;
        check("reset_mid", 160'({bus.out_valid, bus.busy, bus.in_ready, bus.round}), 160'(0));
        tick();
        check("ready_after_mid_reset", 160'({bus.in_ready, bus.out_valid, bus.busy}),
              160'(3'b100));
        run_req("post_reset", K1, C1, P1, 0, 1'b0);

        // Random keys/plaintexts, half of them reusing the previous key
        rkey = rand128();
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 0) rkey = rand128();
            rpt = rand128();
            run_req($sformatf("rand%0d", i), rkey, aes_enc(rkey, rpt), rpt,
                    int'($urandom_range(0, 2)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
